cache_nway_wb: RTL

// - Parametrised N-way set-associative write-back, write-allocate cache between CPU port and word-wide memory port.
// - Next generation of the 4-way cache: way count and line length are parameters, true-LRU victim selection.
// - Adds dirty-victim write-back to memory and critical-word-first refill.
// - Blocking: one outstanding CPU request; sits directly between core load/store unit and memory controller.

---
 rtl/cache_pkg.sv | 45 ++++
 rtl/cache_nway_wb_if.sv | 28 ++
 rtl/cache_lru_nway.sv | 46 ++++
 rtl/cache_nway_wb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the N-way write-back cache.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    HIT,
    WRITEBACK,
    REFILL,
    RESPOND
  } state_t;

  localparam int FIELD_W = 64;

  // Number of byte-select bits below the word index.
  function automatic int byte_off_of(input int word_width);
    return $clog2(word_width / 8);
  endfunction

  // Extract width bits of adr starting at bit lsb.
  function automatic logic [FIELD_W-1:0] field_of(input logic [FIELD_W-1:0] adr,
                                                  input int lsb, input int width);
    logic [FIELD_W-1:0] mask;
    mask = (FIELD_W'(1) << width) - FIELD_W'(1);
    return (adr >> lsb) & mask;
  endfunction

  function automatic logic [FIELD_W-1:0] word_of(input logic [FIELD_W-1:0] adr,
                                                 input int byte_off, input int woff_w);
    return field_of(adr, byte_off, woff_w);
  endfunction

  function automatic logic [FIELD_W-1:0] index_of(input logic [FIELD_W-1:0] adr,
                                                  input int byte_off, input int woff_w,
                                                  input int index_w);
    return field_of(adr, byte_off + woff_w, index_w);
  endfunction

  function automatic logic [FIELD_W-1:0] tag_of(input logic [FIELD_W-1:0] adr,
                                                input int byte_off, input int woff_w,
                                                input int index_w, input int tag_w);
    return field_of(adr, byte_off + woff_w + index_w, tag_w);
  endfunction

endpackage

// File: rtl/cache_nway_wb_if.sv
// CPU-side and memory-side signals of the cache; slave = the cache, master = its environment.
interface cache_nway_wb_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
);
  logic                  cpu_req_i;
  logic                  cpu_rdwr_i;
  logic [ADR_WIDTH-1:0]  cpu_adr_i;
  logic [WORD_WIDTH-1:0] cpu_dat_i;
  logic                  cpu_ack_o;
  logic [WORD_WIDTH-1:0] cpu_dat_o;
  logic                  mem_req_o;
  logic                  mem_we_o;
  logic [ADR_WIDTH-1:0]  mem_adr_o;
  logic [WORD_WIDTH-1:0] mem_dat_o;
  logic                  mem_ack_i;
  logic [WORD_WIDTH-1:0] mem_dat_i;

  modport slave (
    input  cpu_req_i, cpu_rdwr_i, cpu_adr_i, cpu_dat_i, mem_ack_i, mem_dat_i,
    output cpu_ack_o, cpu_dat_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o
  );

  modport master (
    output cpu_req_i, cpu_rdwr_i, cpu_adr_i, cpu_dat_i, mem_ack_i, mem_dat_i,
    input  cpu_ack_o, cpu_dat_o, mem_req_o, mem_we_o, mem_adr_o, mem_dat_o
  );
endinterface

// File: rtl/cache_lru_nway.sv
// True-LRU age tracking: one age per way per set, ages form a permutation of 0..WAY_NUM-1.
module cache_lru_nway #(
  parameter int INDEX_WIDTH = 7,
  parameter int WAY_NUM     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [INDEX_WIDTH-1:0]     index,
  input  logic [$clog2(WAY_NUM)-1:0] way,
  input  logic                       update,
  output logic [$clog2(WAY_NUM)-1:0] lru_way
);
  localparam int AGE_W = $clog2(WAY_NUM);
  localparam int SETS  = 2 ** INDEX_WIDTH;

  logic [AGE_W-1:0] age [SETS][WAY_NUM];
  logic [AGE_W-1:0] old_age;

  assign old_age = age[index][way];

  // Oldest way of the addressed set.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lru_way = '0;
    for (int w = 0; w < WAY_NUM; w++)
      if (age[index][w] == AGE_W'(WAY_NUM - 1)) lru_way = AGE_W'(w);
  end

  // Reset ages to way number; on access, move the way to age 0 and age the younger ones.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAY_NUM; w++)
          age[s][w] <= AGE_W'(w);
    end else if (update) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        if (AGE_W'(w) == way)
          age[index][w] <= '0;
        else if (age[index][w] < old_age)
          age[index][w] <= age[index][w] + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_nway_wb.sv
// N-way set-associative write-back, write-allocate cache with critical-word-first refill.
module cache_nway_wb
  import cache_pkg::*;
#(
  parameter int WORD_WIDTH        = 32,
  parameter int ADR_WIDTH         = 32,
  parameter int INDEX_WIDTH       = 7,
  parameter int WORD_OFFSET_WIDTH = 2,
  parameter int WAY_NUM           = 4
) (
  input logic            clk,
  input logic            rst,
  cache_nway_wb_if.slave bus
);
  localparam int BYTE_OFF  = byte_off_of(WORD_WIDTH);
  localparam int TAG_WIDTH = ADR_WIDTH - INDEX_WIDTH - WORD_OFFSET_WIDTH - BYTE_OFF;
  localparam int AGE_W     = $clog2(WAY_NUM);
  localparam int SETS      = 2 ** INDEX_WIDTH;
  localparam int WORD_NUM  = 2 ** WORD_OFFSET_WIDTH;

  state_t state, state_nxt;

  logic [ADR_WIDTH-1:0]         req_adr;
  logic [WORD_WIDTH-1:0]        req_dat;
  logic                         req_wr;
  logic [AGE_W-1:0]             sel_way;
  logic [WORD_OFFSET_WIDTH-1:0] cnt;
  logic [WORD_WIDTH-1:0]        crit_dat;

  logic [TAG_WIDTH-1:0]  tag_q   [WAY_NUM][SETS];
  logic [SETS-1:0]       valid_q [WAY_NUM];
  logic [SETS-1:0]       dirty_q [WAY_NUM];
  logic [WORD_WIDTH-1:0] data_q  [WAY_NUM][SETS][WORD_NUM];

  logic [TAG_WIDTH-1:0]         req_tag;
  logic [INDEX_WIDTH-1:0]       req_idx;
  logic [WORD_OFFSET_WIDTH-1:0] req_word, ref_word;
  logic                         hit, inv_found, victim_dirty, cnt_last, lru_upd, refill_done;
  logic [AGE_W-1:0]             hit_way, inv_way, victim_way, lru_way;

  assign req_tag  = TAG_WIDTH'(tag_of(64'(req_adr), BYTE_OFF, WORD_OFFSET_WIDTH, INDEX_WIDTH, TAG_WIDTH));
  assign req_idx  = INDEX_WIDTH'(index_of(64'(req_adr), BYTE_OFF, WORD_OFFSET_WIDTH, INDEX_WIDTH));
  assign req_word = WORD_OFFSET_WIDTH'(word_of(64'(req_adr), BYTE_OFF, WORD_OFFSET_WIDTH));
  assign ref_word = req_word + cnt;  // wraps modulo WORD_NUM: critical word first
  assign cnt_last = &cnt;
  assign refill_done = (state == REFILL) && bus.mem_ack_i && cnt_last;

  cache_lru_nway #(.INDEX_WIDTH(INDEX_WIDTH), .WAY_NUM(WAY_NUM)) u_lru (
    .clk     (clk),
    .rst     (rst),
    .index   (req_idx),
    .way     (sel_way),
    .update  (lru_upd),
    .lru_way (lru_way)
  );

  // Tag compare across ways and lowest-numbered invalid way of the set.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAY_NUM; w++) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
      if (!valid_q[w][req_idx] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = AGE_W'(w);
      end
    end
  end

  assign victim_way   = inv_found ? inv_way : lru_way;
  assign victim_dirty = valid_q[victim_way][req_idx] & dirty_q[victim_way][req_idx];

  // Next state and Moore outputs; ack and memory strobes depend on state only.
  always_comb begin
    state_nxt     = state;
    lru_upd       = 1'b0;
    bus.cpu_ack_o = 1'b0;
    bus.cpu_dat_o = '0;
    bus.mem_req_o = 1'b0;
    bus.mem_we_o  = 1'b0;
    bus.mem_adr_o = '0;
    bus.mem_dat_o = '0;
    case (state)
      IDLE:   if (bus.cpu_req_i) state_nxt = LOOKUP;
      LOOKUP: begin
        if (hit)               state_nxt = HIT;
        else if (victim_dirty) state_nxt = WRITEBACK;
        else                   state_nxt = REFILL;
      end
      HIT: begin
        bus.cpu_ack_o = 1'b1;
        bus.cpu_dat_o = data_q[sel_way][req_idx][req_word];
        lru_upd       = 1'b1;
        state_nxt     = IDLE;
      end
      WRITEBACK: begin
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = 1'b1;
        bus.mem_adr_o = {tag_q[sel_way][req_idx], req_idx, cnt, {BYTE_OFF{1'b0}}};
        bus.mem_dat_o = data_q[sel_way][req_idx][cnt];
        if (bus.mem_ack_i && cnt_last) state_nxt = REFILL;
      end
      REFILL: begin
        bus.mem_req_o = 1'b1;
        bus.mem_adr_o = {req_tag, req_idx, ref_word, {BYTE_OFF{1'b0}}};
        if (refill_done) state_nxt = RESPOND;
      end
      RESPOND: begin
        bus.cpu_ack_o = 1'b1;
        bus.cpu_dat_o = crit_dat;
        lru_upd       = 1'b1;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched request, selected way, word counter and captured critical word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req_adr  <= '0;
      req_dat  <= '0;
      req_wr   <= 1'b0;
      sel_way  <= '0;
      cnt      <= '0;
      crit_dat <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (bus.cpu_req_i) begin
          req_adr <= bus.cpu_adr_i;
          req_dat <= bus.cpu_dat_i;
          req_wr  <= bus.cpu_rdwr_i;
        end
        LOOKUP: begin
          sel_way <= hit ? hit_way : victim_way;
          cnt     <= '0;
        end
        WRITEBACK: if (bus.mem_ack_i) cnt <= cnt + 1'b1;
        REFILL: if (bus.mem_ack_i) begin
          cnt <= cnt + 1'b1;
          if (ref_word == req_word) crit_dat <= bus.mem_dat_i;
        end
        default: ;
      endcase
    end
  end

  // Line status bits: cleared by reset, set on refill completion and on write hits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAY_NUM; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else if (state == HIT && req_wr) begin
      dirty_q[sel_way][req_idx] <= 1'b1;
    end else if (refill_done) begin
      valid_q[sel_way][req_idx] <= 1'b1;
      dirty_q[sel_way][req_idx] <= req_wr;
    end
  end

  // Tag and data storage: refill words (write-miss word merged) and write-hit updates.
  // NOTE: storage arrays are not reset; clearing the valid bits is what discards their contents.
  always_ff @(posedge clk) begin
    if (!rst && state == HIT && req_wr)
      data_q[sel_way][req_idx][req_word] <= req_dat;
    if (!rst && state == REFILL && bus.mem_ack_i)
      data_q[sel_way][req_idx][ref_word] <= (req_wr && ref_word == req_word) ? req_dat : bus.mem_dat_i;
    if (!rst && refill_done)
      tag_q[sel_way][req_idx] <= req_tag;
  end

endmodule
